// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns the shared 8-bit LCD write bus.
// - After reset it runs the panel init (display on, start line) on both halves at once.
// - It then serves round-robin tile-write transactions from two drawing engines.
//   Each transaction is: set page, set column, then a stream of data bytes.
// Optional build macro LCD_ARB_GAP_EN: inserts one dead cycle after every bus
// write, for slow panels.
module lcd_bus_arbiter #(
    parameter logic [5:0] START_LINE = 6'd0,
    parameter logic       CS_ACTIVE  = 1'b0,
    parameter logic [6:0] MAX_LEN    = 7'd64
) (
    input  logic        LCD_CLK,
    input  logic        RESETN,
    input  logic [1:0]  REQ,
    input  logic [5:0]  REQ_PAGE,
    input  logic [11:0] REQ_COL,
    input  logic [1:0]  REQ_SIDE,
    input  logic [13:0] REQ_LEN,
    input  logic [15:0] WR_DATA,
    input  logic [1:0]  WR_VALID,
    output logic [1:0]  WR_READY,
    output logic [1:0]  GRANT,
    output logic [1:0]  DONE,
    output logic        BUSY,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_DI,
    output logic        LCD_RW,
    output logic        LCD_ENABLE,
    output logic        LCD_CS1,
    output logic        LCD_CS2,
    output logic        LCD_RSTN,
    output logic [2:0]  DBG_STATE
);

    typedef enum logic [2:0] {
        S_INIT_ON  = 3'd0,
        S_INIT_SL  = 3'd1,
        S_IDLE     = 3'd2,
        S_SET_PAGE = 3'd3,
        S_SET_COL  = 3'd4,
        S_DATA     = 3'd5,
        S_RELEASE  = 3'd6
    } state_t;

    state_t      state_q, state_d;

    // Latched transaction owned by the current grant holder
    logic [1:0]  grant_q;
    logic        owner_q;
    logic        rr_q;        // requester preferred when both ask
    logic [2:0]  page_q;
    logic [5:0]  col_q;
    logic        side_q;
    logic [6:0]  len_q;
    logic [6:0]  cnt_q;

    // Registered bus outputs
    logic [7:0]  data_q;
    logic        di_q;
    logic        en_q;
    logic        cs1_q;
    logic        cs2_q;
    logic [1:0]  done_q;

    // Decisions made by the next-state logic
    logic        wr_en;
    logic        wr_di;
    logic [7:0]  wr_byte;
    logic        load_req;
    logic        load_cnt;
    logic        cnt_dec;
    logic        done_set;
    logic        clr_grant;
    logic        set_cs;

    logic        gap_hold;
    logic        win;
    logic        owner_req;
    logic        own_valid;
    logic [7:0]  own_byte;
    logic        ready_int;
    logic        accept;
    logic [6:0]  len_clamp;

    // Byte handshake: a data byte moves from requester r to the bus on a
    // rising edge where WR_VALID[r] & WR_READY[r]. WR_READY only rises for the
    // grant holder in DATA with bytes still owed; VALID may drop at any time
    // (stall, no timeout) and READY never waits on VALID.
    assign owner_req = REQ[owner_q];
    assign own_valid = WR_VALID[owner_q];
    assign own_byte  = owner_q ? WR_DATA[15:8] : WR_DATA[7:0];
    assign ready_int = (state_q == S_DATA) && (cnt_q != 7'd0) && owner_req && !gap_hold;
    assign accept    = ready_int && own_valid;
    assign len_clamp = (len_q > MAX_LEN) ? MAX_LEN : len_q;
    assign win       = (REQ[0] && REQ[1]) ? rr_q : REQ[1];

`ifdef LCD_ARB_GAP_EN
    logic gap_q;

    // Dead cycle follows every bus write
    always_ff @(posedge LCD_CLK or negedge RESETN) begin
        if (!RESETN) gap_q <= 1'b0;
        else         gap_q <= wr_en;
    end

    assign gap_hold = gap_q;
`else
    assign gap_hold = 1'b0;
`endif

    // Next state and per-cycle bus write decision
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_di     = 1'b0;
        wr_byte   = 8'h00;
        load_req  = 1'b0;
        load_cnt  = 1'b0;
        cnt_dec   = 1'b0;
        done_set  = 1'b0;
        clr_grant = 1'b0;
        set_cs    = 1'b0;
        if (!gap_hold) begin
            case (state_q)
                S_INIT_ON: begin
                    wr_en   = 1'b1;
                    wr_byte = 8'h3F;
                    state_d = S_INIT_SL;
                end
                S_INIT_SL: begin
                    wr_en   = 1'b1;
                    wr_byte = {2'b11, START_LINE};
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (REQ != 2'b00) begin
                        load_req = 1'b1;
                        state_d  = S_SET_PAGE;
                    end
                end
                S_SET_PAGE: begin
                    if (!owner_req) begin
                        clr_grant = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        set_cs  = 1'b1;
                        wr_en   = 1'b1;
                        wr_byte = {5'b10111, page_q};
                        state_d = S_SET_COL;
                    end
                end
                S_SET_COL: begin
                    if (!owner_req) begin
                        clr_grant = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        wr_en    = 1'b1;
                        wr_byte  = {2'b01, col_q};
                        load_cnt = 1'b1;
                        state_d  = (len_clamp == 7'd0) ? S_RELEASE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (!owner_req) begin
                        clr_grant = 1'b1;
                        state_d   = S_IDLE;
                    end else if (cnt_q == 7'd0) begin
                        state_d = S_RELEASE;
                    end else if (accept) begin
                        wr_en   = 1'b1;
                        wr_di   = 1'b1;
                        wr_byte = own_byte;
                        cnt_dec = 1'b1;
                        if (cnt_q == 7'd1) state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    done_set  = 1'b1;
                    clr_grant = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_INIT_ON;
            endcase
        end
    end

    // State register
    always_ff @(posedge LCD_CLK or negedge RESETN) begin
        if (!RESETN) state_q <= S_INIT_ON;
        else         state_q <= state_d;
    end

    // Grant, round-robin pointer, latched request and byte counter
    always_ff @(posedge LCD_CLK or negedge RESETN) begin
        if (!RESETN) begin
            grant_q <= 2'b00;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            page_q  <= 3'd0;
            col_q   <= 6'd0;
            side_q  <= 1'b0;
            len_q   <= 7'd0;
            cnt_q   <= 7'd0;
        end else begin
            if (load_req) begin
                grant_q <= win ? 2'b10 : 2'b01;
                owner_q <= win;
                rr_q    <= ~win;
                page_q  <= win ? REQ_PAGE[5:3]  : REQ_PAGE[2:0];
                col_q   <= win ? REQ_COL[11:6]  : REQ_COL[5:0];
                side_q  <= win ? REQ_SIDE[1]    : REQ_SIDE[0];
                len_q   <= win ? REQ_LEN[13:7]  : REQ_LEN[6:0];
            end else if (clr_grant) begin
                grant_q <= 2'b00;
            end
            if (load_cnt)     cnt_q <= len_clamp;
            else if (cnt_dec) cnt_q <= cnt_q - 7'd1;
        end
    end

    // Registered LCD bus pins and the DONE pulse
    always_ff @(posedge LCD_CLK or negedge RESETN) begin
        if (!RESETN) begin
            data_q <= 8'h00;
            di_q   <= 1'b0;
            en_q   <= 1'b0;
            cs1_q  <= CS_ACTIVE;
            cs2_q  <= CS_ACTIVE;
            done_q <= 2'b00;
        end else begin
            en_q <= wr_en;
            if (wr_en) begin
                data_q <= wr_byte;
                di_q   <= wr_di;
            end
            if (set_cs) begin
                cs1_q <= side_q ? ~CS_ACTIVE : CS_ACTIVE;
                cs2_q <= side_q ? CS_ACTIVE  : ~CS_ACTIVE;
            end
            done_q <= done_set ? grant_q : 2'b00;
        end
    end

    assign WR_READY   = ready_int ? grant_q : 2'b00;
    assign GRANT      = grant_q;
    assign DONE       = done_q;
    assign BUSY       = (state_q != S_IDLE);
    assign LCD_DATA   = data_q;
    assign LCD_DI     = di_q;
    assign LCD_RW     = 1'b0;
    assign LCD_ENABLE = LCD_CLK & en_q;
    assign LCD_CS1    = cs1_q;
    assign LCD_CS2    = cs2_q;
    assign LCD_RSTN   = RESETN;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: randomized requesters against a transaction-level model.
// Expected bus writes and DONE pulses are queued when a round is issued; a
// monitor pops and compares every LCD_ENABLE write and every DONE pulse.
module tb_lcd_bus_arbiter;

    localparam logic CS_A = 1'b0;

    logic        LCD_CLK;
    logic        RESETN;
    logic [1:0]  REQ;
    logic [5:0]  REQ_PAGE;
    logic [11:0] REQ_COL;
    logic [1:0]  REQ_SIDE;
    logic [13:0] REQ_LEN;
    logic [15:0] WR_DATA;
    logic [1:0]  WR_VALID;
    logic [1:0]  WR_READY;
    logic [1:0]  GRANT;
    logic [1:0]  DONE;
    logic        BUSY;
    logic [7:0]  LCD_DATA;
    logic        LCD_DI;
    logic        LCD_RW;
    logic        LCD_ENABLE;
    logic        LCD_CS1;
    logic        LCD_CS2;
    logic        LCD_RSTN;
    logic [2:0]  DBG_STATE;

    // Per-requester pin drivers
    logic        req_a  [2];
    logic        val_a  [2];
    logic [7:0]  wdat_a [2];
    logic [2:0]  pg_a   [2];
    logic [5:0]  cl_a   [2];
    logic        sd_a   [2];
    logic [6:0]  ln_a   [2];

    assign REQ      = {req_a[1], req_a[0]};
    assign WR_VALID = {val_a[1], val_a[0]};
    assign WR_DATA  = {wdat_a[1], wdat_a[0]};
    assign REQ_PAGE = {pg_a[1], pg_a[0]};
    assign REQ_COL  = {cl_a[1], cl_a[0]};
    assign REQ_SIDE = {sd_a[1], sd_a[0]};
    assign REQ_LEN  = {ln_a[1], ln_a[0]};

    // Round parameters per requester
    logic [2:0]  p_pg   [2];
    logic [5:0]  p_cl   [2];
    logic        p_sd   [2];
    logic [6:0]  p_ln   [2];
    logic [7:0]  p_base [2];
    logic [7:0]  p_step [2];
    int          p_mode [2];   // 0 valid always, 1 random stalls, 2 three-cycle stall at byte 2
    int          p_stop [2];   // -1 full transaction, else stop after this many bytes
    int          p_kind [2];   // 1 drop REQ, 2 pulse RESETN
    int          lat_a  [2];
    int          acc_a  [2];

    // Scoreboard: bus write word is {cs1, cs2, di, data}
    logic [10:0] exp_q  [$];
    logic [1:0]  dexp_q [$];
    int          last_served;
    int          checks;
    int          errors;
    int          cyc;

    lcd_bus_arbiter dut (
        .LCD_CLK    (LCD_CLK),
        .RESETN     (RESETN),
        .REQ        (REQ),
        .REQ_PAGE   (REQ_PAGE),
        .REQ_COL    (REQ_COL),
        .REQ_SIDE   (REQ_SIDE),
        .REQ_LEN    (REQ_LEN),
        .WR_DATA    (WR_DATA),
        .WR_VALID   (WR_VALID),
        .WR_READY   (WR_READY),
        .GRANT      (GRANT),
        .DONE       (DONE),
        .BUSY       (BUSY),
        .LCD_DATA   (LCD_DATA),
        .LCD_DI     (LCD_DI),
        .LCD_RW     (LCD_RW),
        .LCD_ENABLE (LCD_ENABLE),
        .LCD_CS1    (LCD_CS1),
        .LCD_CS2    (LCD_CS2),
        .LCD_RSTN   (LCD_RSTN),
        .DBG_STATE  (DBG_STATE)
    );

    // Clock and cycle counter
    initial begin
        LCD_CLK = 1'b0;
        forever #5 LCD_CLK = ~LCD_CLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge LCD_CLK);
            cyc++;
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [7:0] b, input logic [7:0] s, input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return b + s * kk;
    endfunction

    function automatic logic [10:0] word(input logic side, input logic di, input logic [7:0] d);
        logic c1;
        logic c2;
        c1 = side ? ~CS_A : CS_A;
        c2 = side ? CS_A : ~CS_A;
        return {c1, c2, di, d};
    endfunction

    task automatic push_init();
        exp_q.push_back({CS_A, CS_A, 1'b0, 8'h3F});
        exp_q.push_back({CS_A, CS_A, 1'b0, 8'hC0});
    endtask

    // Model of one transaction: page, column, then min(len, 64) bytes
    task automatic push_txn(input int r);
        int nb;
        nb = (p_ln[r] > 7'd64) ? 64 : int'(p_ln[r]);
        if (p_stop[r] >= 0) nb = p_stop[r];
        exp_q.push_back(word(p_sd[r], 1'b0, {5'b10111, p_pg[r]}));
        exp_q.push_back(word(p_sd[r], 1'b0, {2'b01, p_cl[r]}));
        for (int k = 0; k < nb; k++)
            exp_q.push_back(word(p_sd[r], 1'b1, byte_at(p_base[r], p_step[r], k)));
        if (p_stop[r] < 0) dexp_q.push_back((r == 1) ? 2'b10 : 2'b01);
    endtask

    // Monitor: every bus write and DONE pulse is compared against the queues
    initial begin
        logic [10:0] got;
        logic [10:0] e;
        logic [1:0]  d;
        forever begin
            @(posedge LCD_CLK);
            #1;
            if (LCD_ENABLE) begin
                got = {LCD_CS1, LCD_CS2, LCD_DI, LCD_DATA};
                check("lcd_rw", 32'(LCD_RW), 32'd0);
                if (exp_q.size() == 0) begin
                    check("bus_write_unexpected", 32'(got), 32'h7FF);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_write", 32'(got), 32'(e));
                end
            end
            if (DONE != 2'b00) begin
                if (dexp_q.size() == 0) begin
                    check("done_unexpected", 32'(DONE), 32'd0);
                end else begin
                    d = dexp_q.pop_front();
                    check("done_owner", 32'(DONE), 32'(d));
                end
            end
            if (GRANT != 2'b00) begin
                check("grant_onehot", 32'($countones(GRANT)), 32'd1);
                check("ready_nonowner", 32'(WR_READY & ~GRANT), 32'd0);
            end
        end
    end

    // Requester driver: holds REQ until DONE, offers bytes with chosen stall pattern
    task automatic run_req(input int r);
        int idx;
        int t_g;
        int t_d;
        int stalls;
        bit fin;
        bit acc;
        bit v;
        idx = 0; t_g = -1; t_d = -1; stalls = 0; fin = 0;
        pg_a[r] = p_pg[r]; cl_a[r] = p_cl[r]; sd_a[r] = p_sd[r]; ln_a[r] = p_ln[r];
        req_a[r] = 1'b1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (DONE[r]) begin
                t_d = cyc;
                fin = 1;
            end else begin
                if (GRANT[r] && t_g < 0) t_g = cyc;
                v = 1'b1;
                if (p_mode[r] == 1) v = ($urandom_range(0, 3) != 0);
                else if (p_mode[r] == 2 && idx == 2 && stalls < 3 && WR_READY[r]) begin
                    v = 1'b0;
                    stalls++;
                end
                wdat_a[r] = byte_at(p_base[r], p_step[r], idx);
                val_a[r]  = v;
                #1;
                acc = v && WR_READY[r];
                @(posedge LCD_CLK);
                if (acc) idx++;
                @(negedge LCD_CLK);
                if (p_stop[r] >= 0 && idx == p_stop[r]) begin
                    fin = 1;
                    req_a[r] = 1'b0;
                    val_a[r] = 1'b0;
                    if (p_kind[r] == 2) begin
                        RESETN = 1'b0;
                        push_init();
                        #1;
                        check("rst_grant", 32'(GRANT), 32'd0);
                        check("rst_done", 32'(DONE), 32'd0);
                        check("rst_busy", 32'(BUSY), 32'd1);
                        @(negedge LCD_CLK);
                        RESETN = 1'b1;
                        last_served = 1;
                        repeat (3) @(negedge LCD_CLK);
                        check("rst_reinit_idle", 32'(BUSY), 32'd0);
                    end else begin
                        repeat (2) @(negedge LCD_CLK);
                        check("abort_grant", 32'(GRANT[r]), 32'd0);
                        check("abort_idle", 32'(BUSY), 32'd0);
                    end
                end
            end
        end
        req_a[r] = 1'b0;
        val_a[r] = 1'b0;
        if (!fin) check("req_timeout", 32'(idx), 32'hFFFF_FFFF);
        lat_a[r] = t_d - t_g;
        acc_a[r] = idx;
    endtask

    // One round: model decides arbitration order, then both drivers run
    task automatic run_round(input logic [1:0] mask);
        int first;
        if (mask == 2'b11) begin
            first = (last_served == 0) ? 1 : 0;
            push_txn(first);
            push_txn(1 - first);
            last_served = 1 - first;
        end else begin
            first = mask[1] ? 1 : 0;
            push_txn(first);
            last_served = first;
        end
        @(negedge LCD_CLK);
        fork
            begin if (mask[0]) run_req(0); end
            begin if (mask[1]) run_req(1); end
        join
        for (int r = 0; r < 2; r++)
            if (mask[r] && p_stop[r] < 0)
                check("bytes_accepted", 32'(acc_a[r]), (p_ln[r] > 7'd64) ? 32'd64 : 32'(p_ln[r]));
    endtask

    task automatic set_req(input int r, input logic [2:0] pg, input logic [5:0] cl,
                           input logic sd, input logic [6:0] ln, input int mode);
        p_pg[r] = pg; p_cl[r] = cl; p_sd[r] = sd; p_ln[r] = ln; p_mode[r] = mode;
        p_base[r] = 8'($urandom_range(0, 255));
        p_step[r] = 8'($urandom_range(1, 255));
        p_stop[r] = -1;
        p_kind[r] = 0;
    endtask

    task automatic rand_req(input int r);
        logic [6:0] ln;
        case ($urandom_range(0, 5))
            0:       ln = 7'd0;
            1, 2:    ln = 7'($urandom_range(1, 12));
            3:       ln = 7'($urandom_range(60, 70));
            4:       ln = 7'($urandom_range(100, 127));
            default: ln = 7'($urandom_range(1, 4));
        endcase
        set_req(r, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), ln, int'($urandom_range(0, 1)));
    endtask

    // Main sequence
    initial begin
        checks = 0;
        errors = 0;
        last_served = 1;
        RESETN = 1'b0;
        for (int r = 0; r < 2; r++) begin
            req_a[r] = 1'b0; val_a[r] = 1'b0; wdat_a[r] = 8'h00;
            pg_a[r] = 3'd0; cl_a[r] = 6'd0; sd_a[r] = 1'b0; ln_a[r] = 7'd0;
        end
        push_init();
        repeat (3) @(negedge LCD_CLK);
        check("reset_busy", 32'(BUSY), 32'd1);
        check("reset_grant", 32'(GRANT), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_ready", 32'(WR_READY), 32'd0);
        check("reset_data", 32'(LCD_DATA), 32'd0);
        check("reset_di", 32'(LCD_DI), 32'd0);
        check("reset_cs", 32'({LCD_CS1, LCD_CS2}), 32'({CS_A, CS_A}));
        check("reset_lcd_rstn", 32'(LCD_RSTN), 32'd0);
        RESETN = 1'b1;
        @(negedge LCD_CLK);
        check("init_first_byte", 32'(LCD_DATA), 32'h3F);
        check("init_busy", 32'(BUSY), 32'd1);
        @(negedge LCD_CLK);
        check("init_second_byte", 32'(LCD_DATA), 32'hC0);
        check("init_then_idle", 32'(BUSY), 32'd0);
        check("lcd_rstn_follow", 32'(LCD_RSTN), 32'd1);

        // Simultaneous requests straight after reset: requester 0 first
        set_req(0, 3'd1, 6'd10, 1'b0, 7'd3, 0);
        set_req(1, 3'd6, 6'd40, 1'b1, 7'd2, 0);
        run_round(2'b11);

        // Basic transaction: page 3, col 5, left half, 4 bytes
        set_req(0, 3'd3, 6'd5, 1'b0, 7'd4, 0);
        run_round(2'b01);
        check("grant_to_done_len4", 32'(lat_a[0]), 32'd7);

        // Three-cycle VALID drop mid-DATA delays DONE by 3
        set_req(1, 3'd2, 6'd60, 1'b1, 7'd6, 2);
        run_round(2'b10);
        check("grant_to_done_stall", 32'(lat_a[1]), 32'd12);

        // len=0: page and column only
        set_req(0, 3'd7, 6'd63, 1'b0, 7'd0, 0);
        run_round(2'b01);
        check("grant_to_done_len0", 32'(lat_a[0]), 32'd3);

        // len=100 clamps to 64 bytes
        set_req(1, 3'd0, 6'd0, 1'b1, 7'd100, 0);
        run_round(2'b10);
        check("grant_to_done_len100", 32'(lat_a[1]), 32'd67);

        // Owner drops REQ after 3 bytes: no DONE, grant released
        set_req(0, 3'd4, 6'd20, 1'b0, 7'd8, 0);
        p_stop[0] = 3;
        p_kind[0] = 1;
        run_round(2'b01);

        // Randomized rounds
        for (int n = 0; n < 40; n++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            rand_req(0);
            rand_req(1);
            run_round(mask);
        end

        // Reset in the middle of DATA: init reruns, no DONE
        set_req(1, 3'd5, 6'd33, 1'b1, 7'd20, 0);
        p_stop[1] = 5;
        p_kind[1] = 2;
        run_round(2'b10);

        // Pointer back to requester 0 after reset
        set_req(0, 3'd2, 6'd1, 1'b0, 7'd2, 1);
        set_req(1, 3'd3, 6'd2, 1'b1, 7'd3, 1);
        run_round(2'b11);

        repeat (5) @(negedge LCD_CLK);
        check("bus_queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_queue_drained", 32'(dexp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the shared 8-bit LCD write bus and arbitrates it between two drawing engines, for example the head animator and a note/score renderer.
- After reset it runs the display init (display on, start line) on both panel halves.
- It then serves round-robin "tile write" transactions. Each transaction issues set-page, then set-column, then a stream of data bytes to one panel half.
- Requesters never drive LCD pins directly.

Parameters:
- START_LINE, 6'd0: start line written during init.
- CS_ACTIVE, 1'b0: active level of LCD_CS1/LCD_CS2.
- MAX_LEN, 7'd64: upper clamp on a transaction's byte count.

Ports:
- LCD_CLK  input  1  bus clock; all logic on posedge.
- RESETN  input  1  asynchronous, active-low reset.
- REQ  input  2  per-requester transaction request; held high until DONE.
- REQ_PAGE  input  6  {page1[2:0], page0[2:0]}, X page.
- REQ_COL  input  12  {col1[5:0], col0[5:0]}, start column.
- REQ_SIDE  input  2  per requester: 0 = left half (CS1), 1 = right half (CS2).
- REQ_LEN  input  14  {len1[6:0], len0[6:0]}, data byte count.
- WR_DATA  input  16  {data1, data0}, pixel byte.
- WR_VALID  input  2  data byte valid.
- WR_READY  output  2  byte accepted when VALID&READY.
- GRANT  output  2  one-hot, owner of bus.
- DONE  output  2  one-cycle pulse at transaction end.
- BUSY  output  1  high unless in IDLE.
- LCD_DATA  output  8  bus byte.
- LCD_DI  output  1  0 = instruction, 1 = data.
- LCD_RW  output  1  always 0 (write-only).
- LCD_ENABLE  output  1  LCD_CLK & ENABLE_q; the panel latches on the falling edge.
- LCD_CS1  output  1  left half select.
- LCD_CS2  output  1  right half select.
- LCD_RSTN  output  1  = RESETN.

Behaviour:
- Reset (async):
  - State INIT_ON.
  - LCD_DATA=0, LCD_DI=0, LCD_RW=0, ENABLE_q=0.
  - LCD_CS1=LCD_CS2=CS_ACTIVE (broadcast).
  - GRANT=0, DONE=0, WR_READY=0, BUSY=1.
  - Round-robin pointer selects requester 0 first.
- Reset mid-transaction: bus write is killed immediately (LCD_ENABLE low), init reruns, no DONE.
- Every bus write occupies exactly one LCD_CLK cycle with ENABLE_q=1. LCD_DATA/DI/CS are registered in that same cycle.
- State transitions:
  - INIT_ON: write 8'h3F, go to INIT_SL.
  - INIT_SL: write {2'b11, START_LINE}, go to IDLE.
  - IDLE: BUSY=0, ENABLE_q=0. If any REQ is set, latch the winner's page/col/side/len, set GRANT, go to SET_PAGE.
    - If both REQ are set, the requester not served last wins.
    - The pointer flips on every grant.
  - SET_PAGE: CS per latched side (selected = CS_ACTIVE, other inverted). Write {5'b10111, page}, go to SET_COL.
  - SET_COL: write {2'b01, col}, go to DATA. Load byte counter = min(len, MAX_LEN).
  - DATA: WR_READY[owner]=1 while counter>0.
    - On VALID&READY: LCD_DI=1, LCD_DATA=byte, ENABLE_q=1, counter decrements.
    - VALID low: stall, ENABLE_q=0, no timeout.
    - counter==0: go to RELEASE. len=0 goes straight to RELEASE after SET_COL.
  - RELEASE: DONE[owner]=1 for one cycle, GRANT cleared, go to IDLE.
- Data byte latency: byte accepted at posedge N appears on LCD_DATA with ENABLE_q=1 during cycle N+1.
- Column wrap: col+len>64 is not split. The panel's own address auto-increment wraps to column 0 on the same page; the arbiter issues no extra command.
- Abort: REQ[owner] low during SET_PAGE/SET_COL/DATA goes to IDLE next cycle. GRANT clears, no DONE, remaining bytes dropped.
- REQ from the non-owner during a transaction is ignored until IDLE.
- WR_VALID from a non-owner is ignored; its WR_READY stays 0.

Optional Feature:
- LCD_ARB_GAP_EN.
- Defined: one dead cycle (ENABLE_q=0, WR_READY=0) is inserted after every bus write, including init and commands, for slow panels. Data throughput becomes 1 byte/2 cycles; back-to-back latency rules otherwise unchanged.
- Undefined: writes may occur every cycle.

Test Plan:
- Reset release, no REQ -> LCD_DATA 8'h3F then 8'hC0 on consecutive cycles, both CS=CS_ACTIVE, LCD_ENABLE pulsed twice, then BUSY=0.
- REQ[0], page=3, col=5, side=0, len=4, VALID always high -> writes BB, 45, then 4 data bytes with DI=1, CS1 active and CS2 inactive. DONE[0] pulses 7 cycles after GRANT.
- REQ=2'b11 simultaneously after reset -> requester 0 served, then requester 1 granted next IDLE. Bus never shows interleaved bytes.
- Owner drops WR_VALID for 3 cycles mid-DATA -> LCD_ENABLE low those cycles, byte order preserved, DONE delayed by 3.
- len=0 -> page and column writes only, then DONE. len=100 -> exactly 64 data bytes accepted.
- RESETN low during DATA, then released -> no DONE, GRANT=0, init bytes 3F/C0 reissued. With LCD_ARB_GAP_EN, init gap is observed between them.
